// File: rtl/pcpi_issue_stage.sv
// PCPI issue stage: claims M-extension instructions from the core, holds them stable
// for the coprocessor, and returns a single-cycle response (or a watchdog abort).
module pcpi_issue_stage #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            core_valid,
  input  logic [31:0]     core_insn,
  input  logic [XLEN-1:0] core_rs1,
  input  logic [XLEN-1:0] core_rs2,
  output logic            core_wr,
  output logic [XLEN-1:0] core_rd,
  output logic            core_wait,
  output logic            core_ready,
  output logic            cp_valid,
  output logic [31:0]     cp_insn,
  output logic [XLEN-1:0] cp_rs1,
  output logic [XLEN-1:0] cp_rs2,
  input  logic            cp_wr,
  input  logic [XLEN-1:0] cp_rd,
  input  logic            cp_busy,
  input  logic            cp_ready,
  output logic            timeout_err,
  output logic [2:0]      dbg_state
);

  // Handshake: core_valid is a level request. A claimed instruction is answered by
  // exactly one core_ready cycle. cp_valid stays high from ISSUE until cp_ready is
  // sampled in WAIT or the watchdog fires; cp_ready is then expected to fall after
  // cp_valid drops, and DRAIN waits for the coprocessor and core to go quiet.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [31:0]       insn_q, insn_d;
  logic [XLEN-1:0]   rs1_q, rs1_d;
  logic [XLEN-1:0]   rs2_q, rs2_d;
  logic [XLEN-1:0]   rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              claim;

  assign claim = core_valid
              && (core_insn[6:0] == 7'b0110011)
              && (core_insn[31:25] == 7'b0000001);

  always_comb begin
    state_d = state_q;
    insn_d  = insn_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (claim) begin
          insn_d  = core_insn;
          rs1_d   = core_rs1;
          rs2_d   = core_rs2;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A completion seen on the last watchdog cycle still counts as success.
        if (cp_ready) begin
          rd_d    = cp_rd;
          wr_d    = cp_wr;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          rd_d    = '0;
          wr_d    = 1'b0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // A core_valid still held for the finished instruction must not re-issue it.
        if (!cp_ready && !cp_busy && !core_valid) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      insn_q  <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      insn_q  <= insn_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs depend only on state and registers, never directly on inputs.
  assign cp_valid    = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign core_wait   = cp_valid;
  assign core_ready  = (state_q == ST_RESP);
  assign core_wr     = core_ready && wr_q;
  assign core_rd     = core_ready ? rd_q : '0;
  assign timeout_err = core_ready && err_q;
  assign cp_insn     = insn_q;
  assign cp_rs1      = rs1_q;
  assign cp_rs2      = rs2_q;
  assign dbg_state   = state_q;

  a_ready_single: assert property (@(posedge clk) disable iff (!resetn)
    core_ready |=> !core_ready);

  a_ready_not_busy: assert property (@(posedge clk) disable iff (!resetn)
    !(core_ready && (cp_valid || core_wait)));

endmodule
